// File: rtl/frame_fifo.sv
// Multi-channel audio frame FIFO with standard or first-word-fall-through read
// mode, occupancy count, threshold flags and sticky overflow/underflow.
module frame_fifo #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2048,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int FW      = WIDTH * CHANNELS,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [FW-1:0] din,
  input  logic          rd,
  output logic [FW-1:0] dout,
  output logic          valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          udf_q;
  logic          rd_acc;
  logic          wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO still takes a write when a read frees the head slot on the same edge.
  assign rd_acc = rd & ~empty & ~flush;
  assign wr_acc = wr & ~flush & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr && !wr_acc) begin
        ovf_q <= 1'b1;
      end
      if (rd && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head frame is presented combinationally; zero while empty so stale memory never leaks out.
      assign valid = ~empty;
      assign dout  = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [FW-1:0] dout_q;
      logic          valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign valid = valid_q;
      assign dout  = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_frame_fifo.sv
// Drives a standard-mode and a FWFT-mode frame_fifo with identical stimulus and
// checks both against a queue-based reference model.
module tb_frame_fifo;

  localparam int W  = 16;
  localparam int CH = 2;
  localparam int D  = 8;
  localparam int FW = W * CH;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst, flush, wr, rd;
  logic [FW-1:0] din;

  logic [FW-1:0] dout0, dout1;
  logic          valid0, valid1;
  logic [CW-1:0] count0, count1;
  logic          full0, empty0, af0, ae0, ov0, un0;
  logic          full1, empty1, af1, ae1, ov1, un1;

  logic [FW-1:0] q[$];
  bit            m_ov, m_un, m_v0;
  logic [FW-1:0] m_d0;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  frame_fifo #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .din(din), .rd(rd),
    .dout(dout0), .valid(valid0), .count(count0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .overflow(ov0), .underflow(un0)
  );

  frame_fifo #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .din(din), .rd(rd),
    .dout(dout1), .valid(valid1), .count(count1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .overflow(ov1), .underflow(un1)
  );

  function automatic logic [FW-1:0] fr(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  function automatic logic [FW-1:0] fr2(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {~v, v};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model across that edge.
  task automatic applyStimulus(input logic a_rst, input logic a_flush, input logic a_wr,
                               input logic [FW-1:0] a_din, input logic a_rd);
    bit ra, wa;
    rst = a_rst; flush = a_flush; wr = a_wr; din = a_din; rd = a_rd;
    @(posedge clk);
    if (a_rst) begin
      q.delete();
      m_ov = 0; m_un = 0; m_v0 = 0; m_d0 = '0;
    end else if (a_flush) begin
      q.delete();
      m_v0 = 0;
    end else begin
      ra = a_rd && (q.size() > 0);
      wa = a_wr && ((q.size() < D) || ra);
      if (a_rd && !ra) m_un = 1;
      if (a_wr && !wa) m_ov = 1;
      m_v0 = ra;
      if (ra) m_d0 = q.pop_front();
      if (wa) q.push_back(a_din);
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    int n;
    logic [5:0] fexp;
    n = q.size();
    fexp = {n == D, n == 0, n >= 6, n <= 1, m_ov, m_un};
    check({tag, " count0"}, 64'(count0), 64'(n));
    check({tag, " count1"}, 64'(count1), 64'(n));
    check({tag, " flags0"}, 64'({full0, empty0, af0, ae0, ov0, un0}), 64'(fexp));
    check({tag, " flags1"}, 64'({full1, empty1, af1, ae1, ov1, un1}), 64'(fexp));
    check({tag, " valid0"}, 64'(valid0), 64'(m_v0));
    check({tag, " dout0"}, 64'(dout0), 64'(m_d0));
    check({tag, " valid1"}, 64'(valid1), 64'(n > 0));
    if (n > 0) check({tag, " dout1"}, 64'(dout1), 64'(q[0]));
  endtask

  initial begin
    int wbias, rbias, p;
    logic [FW-1:0] exp36 [8];

    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("reset");
    check("reset dout1", 64'(dout1), 64'(0));
    applyStimulus(1, 0, 1, fr(5, 5), 1);
    checkOutput("reset_prio");

    // Fill to depth and drain in order
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, fr(i, 100 + i), 0);
      checkOutput("fill");
    end
    check("full after 8", 64'(full0), 64'(1));
    for (int i = 1; i <= 8; i++) begin
      check("fwft head", 64'(dout1), 64'(fr(i, 100 + i)));
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("drain");
      check("std seq", 64'(dout0), 64'(fr(i, 100 + i)));
    end
    check("empty after 8", 64'(empty0), 64'(1));

    // Overflow on a ninth write
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 1, fr(i, 100 + i), 0);
    applyStimulus(0, 0, 1, fr(9, 109), 0);
    checkOutput("overflow");
    check("ov set", 64'(ov0), 64'(1));
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("ov_drain");
      check("ov seq", 64'(dout0), 64'(fr(i, 100 + i)));
    end
    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("reset2");

    // Underflow is sticky through flush, cleared by reset
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("underflow");
    check("un set", 64'(un1), 64'(1));
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("flush_keep_un");
    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("reset_clr_un");
    check("un clear", 64'(un0), 64'(0));

    // Simultaneous write and read while full
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 1, fr(i, 100 + i), 0);
    applyStimulus(0, 0, 1, fr(20, 120), 1);
    checkOutput("full_wr_rd");
    for (int i = 0; i < 7; i++) exp36[i] = fr(i + 2, 102 + i);
    exp36[7] = fr(20, 120);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, '0, 1);
      checkOutput("full_wr_rd_drain");
      check("wrrd seq", 64'(dout0), 64'(exp36[i]));
    end

    // Continuous stream across several pointer wraps
    applyStimulus(0, 0, 1, fr2(1), 0);
    checkOutput("stream_first");
    check("fwft latency", 64'({valid1, dout1}), 64'({1'b1, fr2(1)}));
    for (int k = 2; k <= 25; k++) begin
      applyStimulus(0, 0, 1, fr2(k), 1);
      checkOutput("stream");
      check("stream std", 64'(dout0), 64'(fr2(k - 1)));
      check("stream fwft", 64'(dout1), 64'(fr2(k)));
    end
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("stream_last");
    check("stream end", 64'(dout0), 64'(fr2(25)));

    // Flush with a concurrent write, then thresholds
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, fr(i, i), 0);
    applyStimulus(0, 1, 1, fr(9, 99), 0);
    checkOutput("flush");
    check("flush empty", 64'({empty0, valid0, count0}), 64'({1'b1, 1'b0, 4'd0}));
    applyStimulus(0, 0, 1, fr(7, 77), 0);
    checkOutput("post_flush_wr");
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("post_flush_rd");
    check("post flush data", 64'(dout0), 64'(fr(7, 77)));
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 0, 1, fr(i, 50 + i), 0);
      checkOutput("thresholds");
    end

    // Randomized traffic with shifting fill/drain bias
    wbias = 50; rbias = 50;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        wbias = $urandom_range(10, 90);
        rbias = $urandom_range(10, 90);
      end
      p = $urandom_range(0, 199);
      applyStimulus(p == 0, (p >= 1) && (p < 4),
                    $urandom_range(0, 99) < wbias, $urandom, $urandom_range(0, 99) < rbias);
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_fifo.md
FRAME_FIFO -- requirements
Module: frame_fifo

Interface
REQ-001 Parameter WIDTH, default 16: bits per audio sample.
REQ-002 Parameter CHANNELS, default 2: samples per frame; frame width FW = WIDTH*CHANNELS, channel k at bits [k*WIDTH +: WIDTH].
REQ-003 Parameter DEPTH, default 2048: frame capacity; power of two, >= 4.
REQ-004 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through.
REQ-005 Parameter AF_LEVEL, default DEPTH-4: almost_full threshold. Parameter AE_LEVEL, default 4: almost_empty threshold.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 flush  input  1  synchronous empty request.
REQ-009 wr  input  1  write strobe, one frame per cycle.
REQ-010 din  input  FW  frame to write.
REQ-011 rd  input  1  read/pop strobe.
REQ-012 dout  output  FW  read frame.
REQ-013 valid  output  1  dout holds a frame (meaning per mode, REQ-020/021).
REQ-014 count  output  clog2(DEPTH)+1  frames stored, 0..DEPTH.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted when wr=1 and (full=0 or read accepted same cycle); frame stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 Read accepted when rd=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-019 count: +1 write only, -1 read only, unchanged both or neither; registered, reflects all operations accepted up to previous edge.
REQ-020 FWFT=0: accepted read at edge N drives head frame on dout and valid=1 in cycle after edge N; valid=0 otherwise; dout holds last value when valid=0.
REQ-021 FWFT=1: valid = ~empty; dout = head frame whenever valid=1; rd pops; frame written into empty FIFO at edge N appears on dout, valid=1, in cycle after edge N.
REQ-022 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL); all consistent with count in same cycle.
REQ-023 wr=1, full=1, no accepted read: write dropped, memory/pointers unchanged, overflow set next cycle.
REQ-024 rd=1, empty=1: read ignored, valid stays 0, underflow set next cycle; simultaneous wr still accepted.
REQ-025 Full with wr=1 and rd=1: both accepted, count stays DEPTH, no overflow.
REQ-026 overflow/underflow remain 1 until rst; flush does not clear them.
REQ-027 flush=1: next cycle pointers=0, count=0, empty=1, valid=0; wr/rd in flush cycle ignored and set no error flags; memory contents not cleared.
REQ-028 Pointer wrap invisible: frame order preserved across any number of DEPTH boundaries.
REQ-029 All CHANNELS samples of one frame written/read atomically; no per-channel skew.

Reset
REQ-030 rst=1 at edge: next cycle count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, dout=0, overflow=0, underflow=0, pointers=0.
REQ-031 rst has priority over flush, wr, rd; rst mid-operation discards stored frames, no partial frame delivered afterward.
REQ-032 Memory contents need not be reset; never visible before being rewritten.

Verification (WIDTH=16, CHANNELS=2, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1, both FWFT values)
REQ-033 Write frames {i, 100+i}, i=1..8, then 8 reads -> dout sequence {1,101}..{8,108} in order; full=1 after 8th write; empty=1 after 8th read; count tracks 0..8..0.
REQ-034 Fill to 8, 9th write of {9,109} -> overflow=1, count=8, reads return {1,101}..{8,108} only.
REQ-035 Empty FIFO, rd=1 -> underflow=1, valid=0, count=0; flush then does not clear underflow; rst does.
REQ-036 Full, wr={20,120} and rd same cycle -> count=8, no overflow, reads return {2,102}..{8,108},{20,120}.
REQ-037 Twenty-five write/read pairs of {i, ~i} streamed continuously (wrap 3+ times) -> all 25 returned in order; FWFT=0 latency 1 cycle, FWFT=1 dout valid cycle after write.
REQ-038 Write 5 frames, assert flush with wr=1 -> next cycle count=0, empty=1, valid=0; then write {7,77} -> read returns {7,77}; almost_full at count 6, almost_empty at count<=1.
